// File: rtl/bcd_stopwatch.sv
// Four-digit BCD stopwatch (SS.hh) with IDLE/RUN/PAUSE control and prescaler.
// Ports: clk, reset (sync, active-high), start_stop, clear -> value[15:0], running, wrap.
// Optional lap hold enabled by macro BCD_STOPWATCH_LAP_EN (adds lap, lap_active).
module bcd_stopwatch #(
  parameter int TICK_DIV = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_stop,
  input  logic        clear,
`ifdef BCD_STOPWATCH_LAP_EN
  input  logic        lap,
  output logic        lap_active,
`endif
  output logic [15:0] value,
  output logic        running,
  output logic        wrap
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [15:0]   count;
  logic [15:0]   count_n;
  logic          tick;
  logic          at_max;
  logic          carry;

  assign tick   = (state == RUN) && (presc == LAST);
  assign at_max = (count == 16'h9999);

  // Ripple increment: a digit at 9 wraps to 0 and passes the carry on.
  always_comb begin
    count_n = count;
    carry   = tick;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (count[4*i +: 4] == 4'd9) begin
          count_n[4*i +: 4] = 4'd0;
        end else begin
          count_n[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state   <= IDLE;
      presc   <= '0;
      count   <= '0;
      running <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      count <= count_n;
      wrap  <= tick && at_max;
      if (state == RUN) begin
        presc <= tick ? '0 : presc + 1'b1;
      end
      if (start_stop) begin
        unique case (state)
          IDLE: begin
            state   <= RUN;
            running <= 1'b1;
          end
          RUN: begin
            state   <= PAUSE;
            running <= 1'b0;
          end
          PAUSE: begin
            state   <= RUN;
            running <= 1'b1;
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef BCD_STOPWATCH_LAP_EN
  logic [15:0] held;
  logic        lap_go;

  assign lap_go = lap && (state == RUN);

  // Display register: frozen snapshot while lap_active, else live count.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lap_active <= 1'b0;
      held       <= '0;
      value      <= '0;
    end else begin
      if (lap_go) begin
        lap_active <= ~lap_active;
      end
      if (lap_go && !lap_active) begin
        held  <= count;
        value <= count;
      end else if (lap_active && !lap_go) begin
        value <= held;
      end else begin
        value <= count_n;
      end
    end
  end
`else
  assign value = count;
`endif

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Randomized and directed bench for bcd_stopwatch at TICK_DIV=4.
// Reference model counts hundredths as an integer and converts to BCD.
module tb_bcd_stopwatch;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_stop = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] value;
  logic        running;
  logic        wrap;
`ifdef BCD_STOPWATCH_LAP_EN
  logic        lap = 1'b0;
  logic        lap_active;
`endif

  int checks = 0;
  int errors = 0;

  int m_n = 0;
  int m_phase = 0;
  int m_mode = 0;
  bit m_wrap = 0;
  bit m_lapact = 0;
  int m_held = 0;

  bcd_stopwatch #(.TICK_DIV(TD)) dut (
    .clk(clk),
    .reset(reset),
    .start_stop(start_stop),
    .clear(clear),
`ifdef BCD_STOPWATCH_LAP_EN
    .lap(lap),
    .lap_active(lap_active),
`endif
    .value(value),
    .running(running),
    .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int n);
    return {4'((n / 1000) % 10), 4'((n / 100) % 10),
            4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic logic [15:0] m_val();
    return m_lapact ? to_bcd(m_held) : to_bcd(m_n);
  endfunction

  task automatic step(input bit ss, input bit clr, input bit rst, input bit lp);
    bit tk;
    start_stop = ss;
    clear = clr;
    reset = rst;
`ifdef BCD_STOPWATCH_LAP_EN
    lap = lp;
`endif
    @(posedge clk);
    if (rst || clr) begin
      m_n = 0;
      m_phase = 0;
      m_mode = 0;
      m_wrap = 0;
      m_lapact = 0;
      m_held = 0;
    end else begin
      tk = (m_mode == 1) && (m_phase == TD - 1);
`ifdef BCD_STOPWATCH_LAP_EN
      if (lp && m_mode == 1) begin
        if (!m_lapact) m_held = m_n;
        m_lapact = !m_lapact;
      end
`else
      if (lp) m_lapact = 0;
`endif
      if (m_mode == 1) m_phase = tk ? 0 : m_phase + 1;
      m_wrap = tk && (m_n == 9999);
      if (tk) m_n = (m_n + 1) % 10000;
      if (ss) m_mode = (m_mode == 1) ? 2 : 1;
    end
    #1;
    start_stop = 1'b0;
    clear = 1'b0;
    reset = 1'b0;
`ifdef BCD_STOPWATCH_LAP_EN
    lap = 1'b0;
`endif
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 1);
      checks++;
      if (value !== 16'h0000) begin
        errors++;
        $display("FAIL reset_value got %h want 0000", value);
      end
      checks++;
      if (running !== 1'b0 || wrap !== 1'b0) begin
        errors++;
        $display("FAIL reset_flags got run=%b wrap=%b want 0 0", running, wrap);
      end
    end
`ifdef BCD_STOPWATCH_LAP_EN
    checks++;
    if (lap_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_lap got %b want 0", lap_active);
    end
`endif
  endtask

  task automatic test_count();
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 0, 0);
      checks++;
      if (value !== m_val()) begin
        errors++;
        $display("FAIL count_track cyc %0d got %h want %h", i, value, m_val());
      end
    end
    checks++;
    if (value !== 16'h0010 || running !== 1'b1) begin
      errors++;
      $display("FAIL count_40 got %h run=%b want 0010 run=1", value, running);
    end
  endtask

  task automatic test_wrap();
    int wraps;
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 50000 && m_n != 9998; i++) begin
      step(0, 0, 0, 0);
      checks++;
      if (value !== m_val() || wrap !== m_wrap) begin
        errors++;
        $display("FAIL wrap_run got %h/%b want %h/%b",
                 value, wrap, m_val(), m_wrap);
      end
    end
    checks++;
    if (m_n != 9998 || value !== 16'h9998) begin
      errors++;
      $display("FAIL wrap_preload got %h want 9998", value);
    end
    wraps = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0);
      if (wrap === 1'b1) wraps++;
      checks++;
      if (wrap !== m_wrap) begin
        errors++;
        $display("FAIL wrap_pulse cyc %0d got %b want %b", i, wrap, m_wrap);
      end
    end
    checks++;
    if (value !== 16'h0000 || wraps != 1 || running !== 1'b1) begin
      errors++;
      $display("FAIL wrap_end got %h wraps=%0d run=%b want 0000 1 1",
               value, wraps, running);
    end
  endtask

  task automatic test_pause();
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL pause_run got %b want 0", running);
    end
    for (int i = 0; i < 100; i++) step(0, 0, 0, 0);
    checks++;
    if (value !== 16'h0001) begin
      errors++;
      $display("FAIL pause_hold got %h want 0001", value);
    end
    step(1, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0);
    checks++;
    if (value !== 16'h0002 || value !== m_val()) begin
      errors++;
      $display("FAIL pause_resume got %h want 0002", value);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    checks++;
    if (value !== 16'h0003 || value !== m_val()) begin
      errors++;
      $display("FAIL pause_remainder got %h want 0003", value);
    end
  endtask

  task automatic test_clear();
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 10000 && m_n != 1234; i++) step(0, 0, 0, 0);
    checks++;
    if (value !== 16'h1234) begin
      errors++;
      $display("FAIL clear_preload got %h want 1234", value);
    end
    step(1, 1, 0, 0);
    checks++;
    if (value !== 16'h0000 || running !== 1'b0) begin
      errors++;
      $display("FAIL clear_win got %h run=%b want 0000 0", value, running);
    end
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
    checks++;
    if (value !== 16'h0000 || running !== 1'b0) begin
      errors++;
      $display("FAIL clear_idle got %h run=%b want 0000 0", value, running);
    end
  endtask

  task automatic test_reset_mid();
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 10000 && m_n != 567; i++) step(0, 0, 0, 0);
    checks++;
    if (value !== 16'h0567) begin
      errors++;
      $display("FAIL rstmid_preload got %h want 0567", value);
    end
    step(1, 0, 1, 0);
    checks++;
    if (value !== 16'h0000 || running !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_edge got %h run=%b want 0000 0", value, running);
    end
    step(1, 1, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    checks++;
    if (value !== 16'h0000 || running !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_ignore got %h run=%b want 0000 0", value, running);
    end
  endtask

`ifdef BCD_STOPWATCH_LAP_EN
  task automatic test_lap();
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 2000 && m_n != 100; i++) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    checks++;
    if (lap_active !== 1'b1 || value !== 16'h0100) begin
      errors++;
      $display("FAIL lap_set got %h act=%b want 0100 1", value, lap_active);
    end
    for (int i = 0; i < 40; i++) step(0, 0, 0, 0);
    checks++;
    if (value !== 16'h0100) begin
      errors++;
      $display("FAIL lap_hold got %h want 0100", value);
    end
    step(0, 0, 0, 1);
    checks++;
    if (value !== 16'h0110 || lap_active !== 1'b0) begin
      errors++;
      $display("FAIL lap_release got %h act=%b want 0110 0", value, lap_active);
    end
  endtask
`endif

  task automatic test_random();
    bit ss, clr, rst, lp;
    step(0, 0, 1, 0);
    for (int i = 0; i < 3000; i++) begin
      ss  = ($urandom % 16) == 0;
      clr = ($urandom % 300) == 0;
      rst = ($urandom % 700) == 0;
      lp  = ($urandom % 25) == 0;
      step(ss, clr, rst, lp);
      checks++;
      if (value !== m_val() || running !== (m_mode == 1) || wrap !== m_wrap) begin
        errors++;
        $display("FAIL random cyc %0d got %h/%b/%b want %h/%b/%b", i,
                 value, running, wrap, m_val(), m_mode == 1, m_wrap);
      end
      for (int d = 0; d < 4; d++) begin
        if (value[4*d +: 4] > 4'd9) begin
          errors++;
          $display("FAIL random_bcd cyc %0d got %h want BCD digits", i, value);
        end
      end
`ifdef BCD_STOPWATCH_LAP_EN
      checks++;
      if (lap_active !== m_lapact) begin
        errors++;
        $display("FAIL random_lap cyc %0d got %b want %b", i, lap_active, m_lapact);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_pause();
    test_clear();
    test_reset_mid();
`ifdef BCD_STOPWATCH_LAP_EN
    test_lap();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
